spi_cp0_ctrl: RTL and testbench
===============================

# spi_cp0_ctrl

Coprocessor-0 SPI master controller driven by the decoder's `spi_ctrl` output. It turns MTC0/MFC0 accesses into register reads and writes and runs a mode-0 SPI transfer of `W_DATA` bits. While a transfer is in flight it stalls the single-cycle CPU on any conflicting coprocessor access. It sits beside the register file and drives the external SPI pins.

## Interface
Parameters:
- `W_DATA`, 8: bits per SPI frame (1..32).
- `DIV_DEFAULT`, 4: reset value of the CLKDIV register.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `spi_ctrl`  in  `W_SPI_CTRL`  `SPI_NOP` / `MT` / `MF` from decode.
- `cp0_sel`  in  `W_REG`  CP0 register index (instruction rd field).
- `wdata`  in  `W_CPU`  value of rt for MTC0.
- `rdata`  out  `W_CPU`  combinational read data for MFC0.
- `stall`  out  1  combinational; holds PC and register write-back.
- `sclk`  out  1  SPI clock, CPOL=0.
- `mosi`  out  1  master out.
- `miso`  in  1  master in.
- `cs_n`  out  1  chip select, active low.

## Operation
- CP0 map:
  - 0 TXDATA: write starts a transfer with `wdata[W_DATA-1:0]`; read returns last TX value.
  - 1 RXDATA: read returns the received frame, zero-extended, and clears `rx_valid`.
  - 2 STATUS: read-only. Bit0 = `busy`, bit1 = `rx_valid`, bit2 = `overrun`.
  - 3 CLKDIV: 8-bit read/write.
  - Any other index reads 0; writes to it are ignored.
- FSM states: IDLE, ASSERT, SHIFT, DEASSERT.
  - IDLE -> ASSERT on accepted MT to TXDATA.
  - ASSERT -> SHIFT after H cycles, where H = CLKDIV+1.
  - SHIFT -> DEASSERT after `W_DATA` full sclk periods.
  - DEASSERT -> IDLE after H cycles.
- Shifting is MSB first:
  - `mosi` is valid before each rising `sclk`.
  - `miso` is sampled on the rising edge.
  - The TX shift register advances on the falling edge.
- On DEASSERT -> IDLE: RXDATA is loaded and `rx_valid` is set. If `rx_valid` was already 1, `overrun` is set as well.
- `overrun` clears on a STATUS read.
- `busy` = (state != IDLE).
- Stall rules, all while busy:
  - MT to TXDATA or CLKDIV stalls.
  - MF of RXDATA stalls.
  - MF of STATUS, MF of TXDATA and MF of CLKDIV never stall.
  - A stalled access is accepted in the cycle `stall` drops, with no side effects before that.
- `spi_ctrl == SPI_NOP` has no effect. Unknown `spi_ctrl` encodings are treated as NOP.

## Timing
- Reset values:
  - `sclk`=0, `mosi`=0, `cs_n`=1, `stall`=0, `rdata`=0.
  - state IDLE, TX/RX registers 0, status bits 0, CLKDIV=`DIV_DEFAULT`.
- `cs_n` falls on the clock edge that accepts the MT. `busy` reads 1 in the next cycle.
- Total busy time is H·(2·`W_DATA`+2) cycles. With `W_DATA`=8 and CLKDIV=0 this is 18 cycles.
- `rx_valid` reads 1 in the first cycle after `cs_n` rises. A stalled RXDATA read completes in that same cycle.
- CLKDIV writes take effect at the next transfer start; the active transfer keeps its latched divisor.
- Reset mid-transfer: every output returns to its reset value on the next edge and the partial RX frame is discarded.

## Configuration
- `SPI_LOOPBACK_EN` defined:
  - The sampled input is `mosi` instead of `miso`.
  - STATUS bit3 reads 1.
- Not defined: `miso` is sampled and STATUS bit3 reads 0.

## Structure
- Shared definitions go in `lib/opcodes.v`:
  - CP0 indices `CP0_TXDATA`, `CP0_RXDATA`, `CP0_STATUS`, `CP0_CLKDIV`.
  - STATUS bit positions.
  - FSM state encodings and `W_SPI_STATE`.
  - The existing `MT`/`MF`/`SPI_NOP` are reused.
- One sub-module, `spi_shifter`: a `W_DATA`-bit parallel-load shift register with sample/shift strobes.
- The FSM, clock divider, CP0 register file and stall logic stay in `spi_cp0_ctrl`.

## Test plan
- Reset, then MF STATUS -> `rdata`=0, `cs_n`=1, CLKDIV reads 4.
- MT CLKDIV=0, then MT TXDATA=0xA5 with `SPI_LOOPBACK_EN` -> `mosi` sequence 1,0,1,0,0,1,0,1; `busy` for 18 cycles; RXDATA reads 0xA5; `rx_valid` then clears.
- MT TXDATA=0x3C, then MF RXDATA issued immediately -> `stall` high until transfer end; read returns 0x3C in the release cycle.
- MT TXDATA while busy -> stall; the second transfer starts the cycle after the first ends and `cs_n` returns high for one cycle between frames.
- Two transfers with no RXDATA read -> STATUS reads 0x6 (`rx_valid`+`overrun`); a second STATUS read returns 0x2.
- Assert `rst` mid-SHIFT -> next edge `cs_n`=1, `sclk`=0, STATUS=0, no stall.

Source files
------------

// File: rtl/spi_cp0_ctrl_pkg.sv
// Shared definitions for the CP0 SPI master: decode opcodes, CP0 register map,
// STATUS bit positions and FSM state encodings.
package spi_cp0_ctrl_pkg;

  localparam int W_SPI_CTRL  = 2;
  localparam int W_REG       = 5;
  localparam int W_CPU       = 32;
  localparam int W_DIV       = 8;
  localparam int W_SPI_STATE = 2;

  localparam logic [W_SPI_CTRL-1:0] SPI_NOP = 2'd0;
  localparam logic [W_SPI_CTRL-1:0] MT      = 2'd1;
  localparam logic [W_SPI_CTRL-1:0] MF      = 2'd2;

  localparam logic [W_REG-1:0] CP0_TXDATA = 5'd0;
  localparam logic [W_REG-1:0] CP0_RXDATA = 5'd1;
  localparam logic [W_REG-1:0] CP0_STATUS = 5'd2;
  localparam logic [W_REG-1:0] CP0_CLKDIV = 5'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_LOOPBACK = 3;

  typedef enum logic [W_SPI_STATE-1:0] {
    SPI_IDLE     = 2'd0,
    SPI_ASSERT   = 2'd1,
    SPI_SHIFT    = 2'd2,
    SPI_DEASSERT = 2'd3
  } spi_state_e;

  function automatic logic [W_CPU-1:0] status_word(input logic busy, input logic rx_valid,
                                                   input logic overrun, input logic loopback);
    logic [W_CPU-1:0] w;
    w              = {W_CPU{1'b0}};
    w[ST_BUSY]     = busy;
    w[ST_RX_VALID] = rx_valid;
    w[ST_OVERRUN]  = overrun;
    w[ST_LOOPBACK] = loopback;
    return w;
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Single W_DATA-bit SPI shift register: MSB drives mosi, the sampled input bit
// is held on the sample strobe and enters at the LSB on the shift strobe.
module spi_shifter #(
  parameter int W_DATA = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_DATA-1:0] load_data,
  input  logic              sample,
  input  logic              shift,
  input  logic              din,
  output logic              dout,
  output logic [W_DATA-1:0] q
);

  logic [W_DATA-1:0] sr_r;
  logic              bit_r;

  // Parallel load, rising-sclk sample and falling-sclk shift
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r  <= {W_DATA{1'b0}};
      bit_r <= 1'b0;
    end else if (load) begin
      sr_r  <= load_data;
      bit_r <= 1'b0;
    end else begin
      if (sample) begin
        bit_r <= din;
      end
      if (shift) begin
        sr_r <= W_DATA'({sr_r, bit_r});
      end
    end
  end

  assign dout = sr_r[W_DATA-1];
  assign q    = sr_r;

endmodule

// File: rtl/spi_cp0_ctrl.sv
// CP0-mapped mode-0 SPI master with CPU stall on conflicting accesses.
// Optional SPI_LOOPBACK_EN: sample mosi instead of miso and report it in STATUS bit3.
module spi_cp0_ctrl
  import spi_cp0_ctrl_pkg::*;
#(
  parameter int W_DATA      = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_SPI_CTRL-1:0] spi_ctrl,
  input  logic [W_REG-1:0]      cp0_sel,
  input  logic [W_CPU-1:0]      wdata,
  output logic [W_CPU-1:0]      rdata,
  output logic                  stall,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

`ifdef SPI_LOOPBACK_EN
  localparam logic LOOPBACK = 1'b1;
`else
  localparam logic LOOPBACK = 1'b0;
`endif

  localparam logic [6:0] HALF_LAST = 7'(2 * W_DATA - 1);

  spi_state_e        state_r;
  logic [W_DIV-1:0]  cnt_r;
  logic [W_DIV-1:0]  div_act_r;
  logic [W_DIV-1:0]  div_r;
  logic [6:0]        half_r;
  logic              sclk_r;
  logic              cs_n_r;
  logic [W_DATA-1:0] tx_data_r;
  logic [W_DATA-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              overrun_r;

  logic              busy_s;
  logic              mt_s;
  logic              mf_s;
  logic              stall_s;
  logic              start_s;
  logic              wr_div_s;
  logic              rd_rx_s;
  logic              rd_status_s;
  logic              phase_done_s;
  logic              sample_s;
  logic              shift_s;
  logic              done_s;
  logic              mosi_s;
  logic              din_s;
  logic [W_DATA-1:0] sh_q_s;
  logic [W_CPU-1:0]  rdata_s;
  logic              unused_s;

  assign busy_s = (state_r != SPI_IDLE);
  assign mt_s   = (spi_ctrl == MT);
  assign mf_s   = (spi_ctrl == MF);

  // Only accesses that would disturb the running frame are held off
  assign stall_s = busy_s &&
                   ((mt_s && ((cp0_sel == CP0_TXDATA) || (cp0_sel == CP0_CLKDIV))) ||
                    (mf_s && (cp0_sel == CP0_RXDATA)));

  assign start_s     = mt_s && (cp0_sel == CP0_TXDATA) && !busy_s;
  assign wr_div_s    = mt_s && (cp0_sel == CP0_CLKDIV) && !busy_s;
  assign rd_rx_s     = mf_s && (cp0_sel == CP0_RXDATA) && !busy_s;
  assign rd_status_s = mf_s && (cp0_sel == CP0_STATUS);

  assign phase_done_s = (cnt_r == 8'd0);
  assign sample_s     = phase_done_s &&
                        ((state_r == SPI_ASSERT) ||
                         ((state_r == SPI_SHIFT) && half_r[0] && (half_r != HALF_LAST)));
  assign shift_s      = phase_done_s && (state_r == SPI_SHIFT) && !half_r[0];
  assign done_s       = phase_done_s && (state_r == SPI_DEASSERT);

`ifdef SPI_LOOPBACK_EN
  assign din_s = mosi_s;
`else
  assign din_s = miso;
`endif

  assign unused_s = &{1'b0, wdata, miso};

  spi_shifter #(
    .W_DATA (W_DATA)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (start_s),
    .load_data (wdata[W_DATA-1:0]),
    .sample    (sample_s),
    .shift     (shift_s),
    .din       (din_s),
    .dout      (mosi_s),
    .q         (sh_q_s)
  );

  // Transfer FSM with half-period divider; sclk and cs_n are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= SPI_IDLE;
      cnt_r     <= 8'd0;
      div_act_r <= 8'd0;
      half_r    <= 7'd0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
    end else begin
      case (state_r)
        SPI_IDLE: begin
          if (start_s) begin
            state_r   <= SPI_ASSERT;
            cnt_r     <= div_r;
            div_act_r <= div_r;
            half_r    <= 7'd0;
            cs_n_r    <= 1'b0;
          end
        end
        SPI_ASSERT: begin
          if (phase_done_s) begin
            state_r <= SPI_SHIFT;
            cnt_r   <= div_act_r;
            half_r  <= 7'd0;
            sclk_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        SPI_SHIFT: begin
          if (phase_done_s) begin
            cnt_r <= div_act_r;
            if (half_r == HALF_LAST) begin
              state_r <= SPI_DEASSERT;
              sclk_r  <= 1'b0;
            end else begin
              half_r <= half_r + 7'd1;
              sclk_r <= ~sclk_r;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        SPI_DEASSERT: begin
          if (phase_done_s) begin
            state_r <= SPI_IDLE;
            cs_n_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= SPI_IDLE;
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
        end
      endcase
    end
  end

  // CP0 register file; a completing frame's overrun set beats a STATUS-read clear
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_r  <= {W_DATA{1'b0}};
      rx_data_r  <= {W_DATA{1'b0}};
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      div_r      <= 8'(DIV_DEFAULT);
    end else begin
      if (start_s) begin
        tx_data_r <= wdata[W_DATA-1:0];
      end
      if (wr_div_s) begin
        div_r <= wdata[W_DIV-1:0];
      end
      if (done_s) begin
        rx_data_r  <= sh_q_s;
        rx_valid_r <= 1'b1;
      end else if (rd_rx_s) begin
        rx_valid_r <= 1'b0;
      end
      if (done_s && rx_valid_r) begin
        overrun_r <= 1'b1;
      end else if (rd_status_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // CP0 read mux, only driven for an accepted MFC0
  always_comb begin
    rdata_s = {W_CPU{1'b0}};
    if (mf_s && !stall_s) begin
      case (cp0_sel)
        CP0_TXDATA: rdata_s = W_CPU'(tx_data_r);
        CP0_RXDATA: rdata_s = W_CPU'(rx_data_r);
        CP0_STATUS: rdata_s = status_word(busy_s, rx_valid_r, overrun_r, LOOPBACK);
        CP0_CLKDIV: rdata_s = W_CPU'(div_r);
        default:    rdata_s = {W_CPU{1'b0}};
      endcase
    end else begin
      rdata_s = {W_CPU{1'b0}};
    end
  end

  assign rdata = rdata_s;
  assign stall = stall_s;
  assign sclk  = sclk_r;
  assign mosi  = mosi_s;
  assign cs_n  = cs_n_r;

endmodule

// File: tb/tb_spi_cp0_ctrl.sv
// Randomized self-checking bench for spi_cp0_ctrl with a transaction-level
// reference model and an SPI slave that shifts out a chosen frame.
module tb_spi_cp0_ctrl;
  import spi_cp0_ctrl_pkg::*;

  localparam int LIMIT = 4000;
`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  spi_ctrl;
  logic [4:0]  cp0_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall, sclk, mosi, miso, cs_n;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic       m_rv, m_ov;
  logic [7:0] m_rx, m_tx, m_div;

  logic [7:0] slave_frame = 8'h00;
  logic [7:0] slave_sr;
  logic       mosi_q[$];

  always #5 clk = ~clk;

  spi_cp0_ctrl #(.W_DATA(8), .DIV_DEFAULT(4)) dut (
    .clk(clk), .rst(rst), .spi_ctrl(spi_ctrl), .cp0_sel(cp0_sel), .wdata(wdata),
    .rdata(rdata), .stall(stall), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  // mode-0 slave: first bit on cs_n fall, next bit after every falling sclk
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge cs_n);
      slave_sr = slave_frame;
      miso     = slave_sr[7];
      for (int k = 0; k < 8; k++) begin
        @(negedge sclk or posedge cs_n);
        if (cs_n) break;
        slave_sr = {slave_sr[6:0], 1'b0};
        miso     = slave_sr[7];
      end
    end
  end

  // record mosi at every rising sclk
  initial begin
    forever begin
      @(posedge sclk);
      mosi_q.push_back(mosi);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    return {28'd0, LB, m_ov, m_rv, busy};
  endfunction

  task automatic drive(input logic [1:0] c, input logic [4:0] s, input logic [31:0] d);
    spi_ctrl = c;
    cp0_sel  = s;
    wdata    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] sel, input logic [31:0] d);
    drive(MT, sel, d);
    @(negedge clk);
    check_eq("wr_stall", {31'd0, stall}, 32'd0);
    step();
    drive(SPI_NOP, 5'd0, 32'd0);
    if (sel == CP0_CLKDIV) m_div = d[7:0];
  endtask

  task automatic cpu_read(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    drive(MF, sel, 32'd0);
    @(negedge clk);
    check_eq(tag, rdata, exp);
    check_eq("rd_stall", {31'd0, stall}, 32'd0);
    step();
    drive(SPI_NOP, 5'd0, 32'd0);
    if (sel == CP0_RXDATA) m_rv = 1'b0;
    if (sel == CP0_STATUS) m_ov = 1'b0;
  endtask

  task automatic complete_model(input logic [7:0] txv, input logic [7:0] slv);
    if (m_rv) m_ov = 1'b1;
    m_rv = 1'b1;
    m_rx = LB ? txv : slv;
  endtask

  task automatic check_mosi(input int base, input logic [7:0] txv);
    logic [7:0] cap;
    cap = 8'd0;
    check_eq("sclk_edges", mosi_q.size() - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < mosi_q.size()) cap = {cap[6:0], mosi_q[base + k]};
    end
    check_eq("mosi_bits", {24'd0, cap}, {24'd0, txv});
  endtask

  task automatic start_xfer(input logic [7:0] txv, input logic [7:0] slv, output int base);
    slave_frame = slv;
    base        = mosi_q.size();
    drive(MT, CP0_TXDATA, {$urandom} & 32'hFFFF_FF00 | {24'd0, txv});
    @(negedge clk);
    check_eq("start_stall", {31'd0, stall}, 32'd0);
    step();
    drive(SPI_NOP, 5'd0, 32'd0);
    m_tx = txv;
    check_eq("cs_fall", {31'd0, cs_n}, 32'd0);
  endtask

  // count busy cycles; optionally issue one access in busy cycle poke_at
  task automatic run_busy(input int poke_at, input int kind, output int n);
    n = 0;
    while (cs_n === 1'b0 && n < LIMIT) begin
      if (n == poke_at) begin
        case (kind)
          0:       drive(MF, CP0_STATUS, 32'd0);
          1:       drive(MT, CP0_CLKDIV, $urandom);
          default: drive(MF, CP0_TXDATA, 32'd0);
        endcase
        @(negedge clk);
        case (kind)
          0: begin
            check_eq("busy_status", rdata, exp_status(1'b1));
            check_eq("busy_status_stall", {31'd0, stall}, 32'd0);
            m_ov = 1'b0;
          end
          1: check_eq("busy_div_stall", {31'd0, stall}, 32'd1);
          default: begin
            check_eq("busy_tx_read", rdata, {24'd0, m_tx});
            check_eq("busy_tx_stall", {31'd0, stall}, 32'd0);
          end
        endcase
      end
      step();
      drive(SPI_NOP, 5'd0, 32'd0);
      n++;
    end
  endtask

  initial begin
    int n, base, base_b, k;
    int unsigned t;
    logic [7:0] txv, slv, div;

    rst = 1'b1;
    drive(SPI_NOP, 5'd0, 32'd0);
    m_rv = 1'b0; m_ov = 1'b0; m_rx = 8'd0; m_tx = 8'd0; m_div = 8'd4;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check_eq("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("rst_sclk", {31'd0, sclk}, 32'd0);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    cpu_read("rst_status", CP0_STATUS, exp_status(1'b0));
    cpu_read("rst_clkdiv", CP0_CLKDIV, 32'd4);
    cpu_read("rst_tx", CP0_TXDATA, 32'd0);
    cpu_read("rst_rx", CP0_RXDATA, 32'd0);

    // fastest divisor, 0xA5
    cpu_write(CP0_CLKDIV, 32'd0);
    start_xfer(8'hA5, 8'hA5, base);
    run_busy(-1, 0, n);
    check_eq("a5_busy_len", n, 32'd18);
    complete_model(8'hA5, 8'hA5);
    check_mosi(base, 8'hA5);
    cpu_read("a5_status", CP0_STATUS, exp_status(1'b0));
    cpu_read("a5_rx", CP0_RXDATA, {24'd0, m_rx});
    cpu_read("a5_status2", CP0_STATUS, exp_status(1'b0));

    // RXDATA read issued right after start stalls until the frame lands
    start_xfer(8'h3C, 8'hC3, base);
    drive(MF, CP0_RXDATA, 32'd0);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall || n >= LIMIT) break;
      n++;
      @(posedge clk);
      #1;
    end
    complete_model(8'h3C, 8'hC3);
    check_eq("rxstall_len", n, 32'd18);
    check_eq("rxstall_data", rdata, {24'd0, m_rx});
    check_eq("rxstall_cs_n", {31'd0, cs_n}, 32'd1);
    step();
    m_rv = 1'b0;
    drive(SPI_NOP, 5'd0, 32'd0);
    check_mosi(base, 8'h3C);

    // back-to-back frames, second one stalled behind the first
    start_xfer(8'h96, 8'h0F, base);
    drive(MT, CP0_TXDATA, 32'h0000_001E);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall || n >= LIMIT) break;
      n++;
      @(posedge clk);
      #1;
    end
    check_eq("b2b_stall_len", n, 32'd18);
    check_eq("b2b_gap_cs_n", {31'd0, cs_n}, 32'd1);
    complete_model(8'h96, 8'h0F);
    check_mosi(base, 8'h96);
    slave_frame = 8'hE1;
    base_b      = mosi_q.size();
    step();
    drive(SPI_NOP, 5'd0, 32'd0);
    m_tx = 8'h1E;
    check_eq("b2b_start", {31'd0, cs_n}, 32'd0);
    run_busy(-1, 0, n);
    check_eq("b2b_busy_len", n, 32'd18);
    complete_model(8'h1E, 8'hE1);
    check_mosi(base_b, 8'h1E);
    cpu_read("ovr_status", CP0_STATUS, exp_status(1'b0));
    cpu_read("ovr_status2", CP0_STATUS, exp_status(1'b0));
    cpu_read("ovr_rx", CP0_RXDATA, {24'd0, m_rx});

    // randomized frames with random divisors and a mid-frame access
    for (int i = 0; i < 12; i++) begin
      div = 8'($urandom_range(0, 3));
      txv = 8'($urandom);
      slv = 8'($urandom);
      t = $urandom;
      t[7:0] = div;
      cpu_write(CP0_CLKDIV, t);
      start_xfer(txv, slv, base);
      run_busy($urandom_range(0, 18 * (int'(div) + 1) - 1), $urandom_range(0, 2), n);
      check_eq("rnd_busy_len", n, 32'(18 * (int'(div) + 1)));
      complete_model(txv, slv);
      check_mosi(base, txv);
      cpu_read("rnd_clkdiv", CP0_CLKDIV, {24'd0, m_div});
      case ($urandom_range(0, 3))
        0: cpu_read("rnd_rx", CP0_RXDATA, {24'd0, m_rx});
        1: cpu_read("rnd_status", CP0_STATUS, exp_status(1'b0));
        2: begin
          cpu_read("rnd_status", CP0_STATUS, exp_status(1'b0));
          cpu_read("rnd_rx", CP0_RXDATA, {24'd0, m_rx});
        end
        default: ;
      endcase
    end
    cpu_read("rnd_tx", CP0_TXDATA, {24'd0, m_tx});

    // unknown encodings and unmapped or read-only indices
    drive(2'd3, CP0_TXDATA, 32'h0000_00FF);
    step();
    drive(SPI_NOP, 5'd0, 32'd0);
    check_eq("bad_ctrl_cs_n", {31'd0, cs_n}, 32'd1);
    cpu_write(5'd7, 32'hFFFF_FFFF);
    cpu_read("unmapped_rd", 5'd7, 32'd0);
    cpu_write(CP0_STATUS, 32'hFFFF_FFFF);
    cpu_read("ro_status", CP0_STATUS, exp_status(1'b0));

    // reset in the middle of SHIFT
    cpu_write(CP0_CLKDIV, 32'd1);
    start_xfer(8'hFF, 8'hFF, base);
    k = 0;
    while (sclk !== 1'b1 && k < LIMIT) begin
      step();
      k++;
    end
    check_eq("pre_rst_sclk", {31'd0, sclk}, 32'd1);
    rst = 1'b1;
    drive(MF, CP0_RXDATA, 32'd0);
    step();
    check_eq("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    check_eq("mid_rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    drive(SPI_NOP, 5'd0, 32'd0);
    m_rv = 1'b0; m_ov = 1'b0; m_rx = 8'd0; m_tx = 8'd0; m_div = 8'd4;
    cpu_read("post_rst_status", CP0_STATUS, exp_status(1'b0));
    cpu_read("post_rst_clkdiv", CP0_CLKDIV, {24'd0, m_div});
    cpu_read("post_rst_rx", CP0_RXDATA, 32'd0);
    cpu_read("post_rst_tx", CP0_TXDATA, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
